if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS core. It holds the PC, issues requests to instruction memory with a request/acknowledge handshake, and loads the IF/ID pipeline register. The decode stage slices `id_instr[31:26]` from that register and feeds it to the main decoder. Hazard stall and branch/jump redirect from later stages are honoured here.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset. Bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; always word-aligned.
- `imem_ack`  in  1  response valid this cycle for the current `imem_addr`.
- `imem_rdata`  in  32  instruction word; valid while `imem_ack`=1.
- `stall`  in  1  hazard unit: ID must hold its contents.
- `redirect`  in  1  taken branch or jump: flush and refetch.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored and forced to 0.
- `id_valid`  out  1  IF/ID register holds a live instruction.
- `id_instr`  out  32  IF/ID instruction.
- `id_pc`  out  32  address of `id_instr`.
- `id_pc_plus4`  out  32  `id_pc` + 4, modulo 2^32.

## Operation
- **Registers:** `pc`, FSM state, 32-bit hold buffer `hbuf`, and the IF/ID register.
- **Reset (`rst_n`=0 at a clock edge):**
  - `pc`=`RESET_PC`, state=IDLE.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `id_valid`=0, `id_instr`=0, `id_pc`=0, `id_pc_plus4`=0, `hbuf`=0.
  - Reset wins over every other input.
- **IDLE:**
  - `imem_req`=0.
  - Next state is FETCH unconditionally.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - The address changes only after an ack or on a redirect.
- **HOLD:**
  - `imem_req`=0.
  - A fetched word waits in `hbuf` because ID is stalled.
- **Priority per cycle:** `redirect` > `stall` > `imem_ack`.
- **`redirect`=1, any state:**
  - `pc`←`{redirect_pc[31:2],2'b00}`, `id_valid`←0, `hbuf` discarded, state←FETCH.
  - A simultaneous ack is dropped.
  - This applies even while `stall`=1.
- **FETCH, ack, `stall`=0:**
  - `id_instr`←`imem_rdata`, `id_pc`←`pc`, `id_pc_plus4`←`pc`+4, `id_valid`←1.
  - `pc`←`pc`+4; stay in FETCH.
- **FETCH, ack, `stall`=1:**
  - `hbuf`←`imem_rdata`, `pc`←`pc`+4, state←HOLD.
  - IF/ID register is unchanged.
- **FETCH, no ack:**
  - `stall`=0: `id_valid`←0 (bubble); other IF/ID fields don't-care.
  - `stall`=1: IF/ID register is unchanged.
- **HOLD, `stall`=0:**
  - `id_instr`←`hbuf`, `id_pc`←`pc`−4, `id_pc_plus4`←`pc`, `id_valid`←1.
  - State←FETCH.
- **HOLD, `stall`=1:** everything holds.
- **Arithmetic:** all PC arithmetic is 32-bit and wraps; `32'hFFFF_FFFC`+4 = `32'h0000_0000`.

## Timing
- After `rst_n` goes high at edge R: IDLE during cycle R+1, first `imem_req`=1 in cycle R+2.
- Ack in cycle N with no stall or redirect: `id_valid`=1 and `id_instr` = that word in cycle N+1.
- Zero-wait memory (`imem_ack` tied high): one instruction per cycle, `imem_addr` increments by 4 every cycle.
- Redirect sampled at edge E: `imem_addr`=target in cycle E+1; target reaches ID no earlier than E+2.
- Stall released at edge S from HOLD: buffered word is in ID at S+1; the next request is issued at S+1.
- Every output is registered or decoded from registered state; there is no combinational path from any input to any output.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds ports `perf_fetch_cnt` out 32 and `perf_stall_cnt` out 32.
  - `perf_fetch_cnt` increments whenever the IF/ID register is loaded with `id_valid`←1.
  - `perf_stall_cnt` increments every cycle with `stall`=1 and `id_valid`=1.
  - Both reset to 0 and wrap at 2^32.
- `IF_PERF_CNT_EN` undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- **Reset and streaming:** `RESET_PC`=`32'h0000_0040`, ack always 1, rdata=`32'h2008_0005` (addi) → first `imem_addr`=`0x40`; next cycle `id_instr`=`0x20080005`, `id_pc`=`0x40`, `id_pc_plus4`=`0x44`; `imem_addr`=`0x44`, `0x48`, … consecutively.
- **Wait states:** ack asserted every third cycle → `imem_addr` stable between acks; `id_valid` pulses 1 for one cycle after each ack, 0 otherwise.
- **Stall with HOLD:** ack of `0x8C09_0004` (lw) while `stall`=1 for 3 cycles → `imem_req`=0 and IF/ID unchanged for 3 cycles; one cycle after stall drops, `id_instr`=`0x8C090004`; fetching resumes at `pc`+4.
- **Redirect:** `redirect`=1, `redirect_pc`=`32'h0000_0103`, with ack and stall high in the same cycle → next cycle `id_valid`=0, `imem_addr`=`0x100`, `hbuf` dropped.
- **Wrap:** `pc`=`0xFFFF_FFFC` acked → `id_pc_plus4`=`0x0000_0000`, next `imem_addr`=`0x0`.
- **Reset mid-HOLD:** `rst_n`=0 for one edge → all outputs at reset values; restart at `RESET_PC` per the reset timing. With `IF_PERF_CNT_EN` defined, both counters read 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the pipelined MIPS core.
//
// Holds the PC, requests instruction words from memory over a req/ack
// handshake and loads the IF/ID pipeline register. Honours hazard stall
// and branch/jump redirect from later stages; redirect outranks stall,
// which outranks a memory ack.
//
// Optional build macro: IF_PERF_CNT_EN adds the fetch and stall
// performance counters.
//
// Parameters
//   RESET_PC     PC loaded on reset (must be word-aligned)
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   imem_req     fetch request valid
//   imem_addr    fetch address, word-aligned
//   imem_ack     memory response valid for the current imem_addr
//   imem_rdata   instruction word, valid with imem_ack
//   stall        ID must hold its contents
//   redirect     taken branch / jump: flush and refetch
//   redirect_pc  redirect target (low two bits ignored)
//   id_valid     IF/ID holds a live instruction
//   id_instr     IF/ID instruction
//   id_pc        address of id_instr
//   id_pc_plus4  id_pc + 4 (wraps)
//   perf_fetch_cnt  (IF_PERF_CNT_EN) IF/ID loads with a live instruction
//   perf_stall_cnt  (IF_PERF_CNT_EN) cycles with stall and id_valid high
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] hbuf;
  logic [31:0] tgt;
  logic        acc;

  function automatic logic [31:0] pc_fwd(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  function automatic logic [31:0] pc_back(input logic [31:0] a);
    return a - 32'd4;
  endfunction

  assign tgt = redirect_pc & 32'hFFFF_FFFC;
  // A memory ack only counts while requesting and not being flushed.
  assign acc = (state == FETCH) && imem_ack && !redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = FETCH;
        FETCH:   if (imem_ack && stall) state_nxt = HOLD;
        HOLD:    if (!stall) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state == FETCH);
    imem_addr = pc;
  end

  // ---- IF -> IF/ID boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      hbuf        <= '0;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (redirect) begin
      pc       <= tgt;
      hbuf     <= '0;
      id_valid <= 1'b0;
    end else if (stall) begin
      // ID is frozen; an arriving word is parked until the stall clears.
      if (acc) begin
        hbuf <= imem_rdata;
        pc   <= pc_fwd(pc);
      end
    end else if (acc) begin
      id_instr    <= imem_rdata;
      id_pc       <= pc;
      id_pc_plus4 <= pc_fwd(pc);
      id_valid    <= 1'b1;
      pc          <= pc_fwd(pc);
    end else if (state == HOLD) begin
      // pc already advanced past the parked word when it was captured.
      id_instr    <= hbuf;
      id_pc       <= pc_back(pc);
      id_pc_plus4 <= pc;
      id_valid    <= 1'b1;
    end else begin
      id_valid <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic load;

  assign load = !redirect && !stall && (acc || (state == HOLD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall && id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_stage #(.RESET_PC(32'h0000_0040)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic        stall_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) stall_q <= stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a fresh IF/ID load is visible when id_valid is high and the
  // preceding edge saw no stall.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && id_valid && !stall_q) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_id: got instr %h pc %h expected none", id_instr, id_pc);
      end else begin
        e = q.pop_front();
        chk("id_instr", id_instr, e.instr);
        chk("id_pc", id_pc, e.pc);
        chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  // One clock of stimulus; checks the request side before the edge and
  // queues the word an accepted ack should deliver to ID.
  task automatic cyc(input logic ack, input logic [31:0] rd, input logic st,
                     input logic rdr, input logic [31:0] rpc, input logic exp_req);
    imem_ack    = ack;
    imem_rdata  = rd;
    stall       = st;
    redirect    = rdr;
    redirect_pc = rpc;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, exp_pc);
    if (rdr) begin
      exp_pc = rpc & 32'hFFFF_FFFC;
    end else if (ack && exp_req) begin
      q.push_back('{rd, exp_pc});
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0040);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_word;
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    exp_pc      = 32'h0000_0040;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;

    // IDLE cycle, then streaming with ack tied high
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h2009_0006, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h200A_0007, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h200B_0008, 1'b0, 1'b0, 32'h0, 1'b1);

    // Wait states: ack every third cycle
    last_word = '0;
    for (int r = 0; r < 3; r++) begin
      cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("bubble_valid", 32'(id_valid), 32'd0);
      cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("bubble_valid", 32'(id_valid), 32'd0);
      last_word = 32'h0128_4020 + 32'(r);
      cyc(1'b1, last_word, 1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Stall with HOLD: lw acked under stall, held three cycles
    cyc(1'b1, 32'h8C09_0004, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold_id_instr", id_instr, last_word);
    chk("hold_id_valid", 32'(id_valid), 32'd1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_id_instr", id_instr, last_word);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_id_instr", id_instr, last_word);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("unhold_id_instr", id_instr, 32'h8C09_0004);
    cyc(1'b1, 32'h012A_4020, 1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with ack and stall in the same cycle
    cyc(1'b1, 32'hBAD0_0001, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
    chk("redir_id_valid", 32'(id_valid), 32'd0);
    cyc(1'b1, 32'h1000_FFFF, 1'b0, 1'b0, 32'h0, 1'b1);

    // PC wrap
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    cyc(1'b1, 32'h0800_0010, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_plus4", id_pc_plus4, 32'h0000_0000);
    cyc(1'b1, 32'h2129_0001, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while in HOLD
    cyc(1'b1, 32'h8C0A_0008, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    chk_reset();
    rst_n  = 1'b1;
    exp_pc = 32'h0000_0040;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
